ex_result_buffer: RTL

//  EX->MEM result stage directly downstream of the ALU. Captures alu_out, the flags and the

---
 rtl/ex_result_buffer.sv | 82 ++++++++
 1 files changed

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: EX->MEM two-entry skid buffer with overflow trap kill, exception pulse and saturating counter
module ex_result_buffer #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   alu_out,
  input  logic            neg_f,
  input  logic            over_f,
  input  logic            zero_f,
  input  logic [RW-1:0]   in_wsel,
  input  logic            in_regwen,
  input  logic            in_trap_ovf,
  input  logic [DW-1:0]   in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_result,
  output logic            out_zero,
  output logic            out_neg,
  output logic [RW-1:0]   out_wsel,
  output logic            out_regwen,
  output logic            ovf_exc,
  output logic [DW-1:0]   exc_pc,
  output logic [CNTW-1:0] ovf_count
);
  localparam int EW = DW + RW + 3;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t          state_q, state_d;
  logic [EW-1:0]   head_q, head_d, skid_q, in_ent;
  logic            in_ready_q, ovf_exc_q, push, pop, trap, load_head, load_skid;
  logic [DW-1:0]   exc_pc_q;
  logic [CNTW-1:0] cnt_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign trap      = over_f & in_trap_ovf;
  assign in_ent    = {alu_out, zero_f, neg_f, in_wsel, in_regwen & ~trap};
  assign load_head = !flush && ((push && (state_q == EMPTY || pop)) || (state_q == TWO && pop));
  assign load_skid = !flush && push && !pop && state_q == ONE;
  assign head_d    = (state_q == TWO) ? skid_q : in_ent;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= EMPTY;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = flush ? EMPTY :
              (state_q == EMPTY) ? (push ? ONE : EMPTY) :
              (state_q == ONE)   ? ((push && !pop) ? TWO : (!push && pop) ? EMPTY : ONE) :
                                   (pop ? ONE : TWO);
  end
  always_comb begin
    out_valid = state_q != EMPTY;
    in_ready  = in_ready_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      ovf_exc_q  <= 1'b0;
      exc_pc_q   <= '0;
      cnt_q      <= '0;
    end else begin
      in_ready_q <= state_d != TWO;
      ovf_exc_q  <= push & trap & ~flush;
      if (load_head) head_q <= head_d;
      if (load_skid) skid_q <= in_ent;
      if (push && trap && !flush) begin
        exc_pc_q <= in_pc;
        cnt_q    <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end
  assign {out_result, out_zero, out_neg, out_wsel, out_regwen} = head_q;
  assign ovf_exc   = ovf_exc_q;
  assign exc_pc    = exc_pc_q;
  assign ovf_count = cnt_q;
endmodule
